// File: rtl/tecmo_sdram_pkg.sv
// Shared definitions for the three-port SDRAM arbiter: port count, port
// indices, arbiter state encoding and a one-hot helper.
package tecmo_sdram_pkg;

    localparam int NUM_PORTS = 3;

    // Port indices: 0 = bridge download, 1 = CPU ROM, 2 = graphics ROM
    localparam logic [1:0] PORT_DL  = 2'd0;
    localparam logic [1:0] PORT_CPU = 2'd1;
    localparam logic [1:0] PORT_GFX = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    // Convert a port index into its one-hot strobe position
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] idx);
        case (idx)
            PORT_DL:  return 3'b001;
            PORT_CPU: return 3'b010;
            PORT_GFX: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/sdram_arbiter_pick.sv
// Combinational grant selection: port 0 has absolute priority, ports 1 and 2
// share the remaining slots round-robin. ptr = 0 favours port 1, ptr = 1
// favours port 2.
module sdram_arbiter_pick
    import tecmo_sdram_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 valid
);

    // Fixed priority for port 0, then round-robin between ports 1 and 2
    always_comb begin
        grant = 3'b000;
        valid = |req;
        if (req[PORT_DL]) begin
            grant = 3'b001;
        end else if (!ptr) begin
            if (req[PORT_CPU]) begin
                grant = 3'b010;
            end else if (req[PORT_GFX]) begin
                grant = 3'b100;
            end else begin
                grant = 3'b000;
            end
        end else begin
            if (req[PORT_GFX]) begin
                grant = 3'b100;
            end else if (req[PORT_CPU]) begin
                grant = 3'b010;
            end else begin
                grant = 3'b000;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-port SDRAM arbiter. One transaction is outstanding at a time: the
// winning port's command is latched in IDLE, presented to the controller in
// REQ until acked, and reads then wait in WAIT for the data strobe.
module sdram_arbiter
    import tecmo_sdram_pkg::*;
#(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_req,
    input  logic [NUM_PORTS-1:0]            in_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] in_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_din,
    output logic [NUM_PORTS-1:0]            in_ack,
    output logic [NUM_PORTS-1:0]            in_valid,
    output logic [DATA_WIDTH-1:0]           in_dout,
    output logic                            sdram_req,
    output logic                            sdram_we,
    output logic [ADDR_WIDTH-1:0]           sdram_addr,
    output logic [DATA_WIDTH-1:0]           sdram_din,
    input  logic                            sdram_ack,
    input  logic                            sdram_valid,
    input  logic [DATA_WIDTH-1:0]           sdram_dout,
    output logic                            busy
);

    arb_state_t              r_state;
    logic [1:0]              r_owner;
    logic                    r_ptr;
    logic                    r_sdram_req;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_din;
    logic                    r_busy;

    logic [NUM_PORTS-1:0]    w_grant;
    logic                    w_pick_valid;
    logic [1:0]              w_idx;
    logic                    w_sel_we;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_din;

    sdram_arbiter_pick u_pick (
        .req   (in_req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .valid (w_pick_valid)
    );

    // Route the granted port's command fields to the capture registers
    always_comb begin
        w_idx      = PORT_DL;
        w_sel_we   = in_we[PORT_DL];
        w_sel_addr = in_addr[0 +: ADDR_WIDTH];
        w_sel_din  = in_din[0 +: DATA_WIDTH];
        case (w_grant)
            3'b010: begin
                w_idx      = PORT_CPU;
                w_sel_we   = in_we[PORT_CPU];
                w_sel_addr = in_addr[ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_din  = in_din[DATA_WIDTH +: DATA_WIDTH];
            end
            3'b100: begin
                w_idx      = PORT_GFX;
                w_sel_we   = in_we[PORT_GFX];
                w_sel_addr = in_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_din  = in_din[2*DATA_WIDTH +: DATA_WIDTH];
            end
            default: begin
                w_idx      = PORT_DL;
                w_sel_we   = in_we[PORT_DL];
                w_sel_addr = in_addr[0 +: ADDR_WIDTH];
                w_sel_din  = in_din[0 +: DATA_WIDTH];
            end
        endcase
    end

    // Arbiter FSM: capture a grant in IDLE, hold the command through REQ, wait for read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= PORT_DL;
            r_ptr       <= 1'b0;
            r_sdram_req <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state     <= ST_REQ;
                        r_owner     <= w_idx;
                        r_we        <= w_sel_we;
                        r_addr      <= w_sel_addr;
                        r_din       <= w_sel_din;
                        r_sdram_req <= 1'b1;
                        r_busy      <= 1'b1;
                        // Port 0 wins leave the round-robin turn untouched
                        if (w_grant[PORT_CPU]) begin
                            r_ptr <= 1'b1;
                        end else if (w_grant[PORT_GFX]) begin
                            r_ptr <= 1'b0;
                        end else begin
                            r_ptr <= r_ptr;
                        end
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        r_sdram_req <= 1'b0;
                        if (r_we) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sdram_valid) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_sdram_req <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Forward controller handshakes to the owning port only in the phase that expects them
    always_comb begin
        in_ack   = 3'b000;
        in_valid = 3'b000;
        if ((r_state == ST_REQ) && sdram_ack) begin
            in_ack = port_onehot(r_owner);
        end else begin
            in_ack = 3'b000;
        end
        if ((r_state == ST_WAIT) && sdram_valid) begin
            in_valid = port_onehot(r_owner);
        end else begin
            in_valid = 3'b000;
        end
    end

    assign in_dout    = sdram_dout;
    assign sdram_req  = r_sdram_req;
    assign sdram_we   = r_we;
    assign sdram_addr = r_addr;
    assign sdram_din  = r_din;
    assign busy       = r_busy;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized
// traffic, all compared every cycle against a transaction-level model.
module tb_sdram_arbiter;

    localparam int AW = 23;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      in_req, in_we, in_ack, in_valid;
    logic [3*AW-1:0] in_addr;
    logic [3*DW-1:0] in_din;
    logic [DW-1:0]   in_dout, sdram_din, sdram_dout;
    logic [AW-1:0]   sdram_addr;
    logic            sdram_req, sdram_we, sdram_ack, sdram_valid, busy;

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_req(in_req), .in_we(in_we), .in_addr(in_addr),
        .in_din(in_din), .in_ack(in_ack), .in_valid(in_valid), .in_dout(in_dout),
        .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
        .sdram_din(sdram_din), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid),
        .sdram_dout(sdram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: phase 0 = free, 1 = command outstanding, 2 = awaiting read data
    int            m_phase, m_owner, m_next;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic          m_we;

    // Requesters and controller environment
    logic [2:0]    pend, waitv, last_ack, last_valid;
    logic [AW-1:0] pa [3];
    logic [DW-1:0] pd [3];
    logic          pw [3];
    int            prob [3];
    int            ack_dly, val_dly, ctl_cnt;
    bit            rnd_dly, spur;

    int cyc = 0;
    int ack_log[$];
    int t_valid0, t_req1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [2:0] r);
        if (r[0]) return 0;
        if (r[m_next]) return m_next;
        if (r[3 - m_next]) return 3 - m_next;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_next  = 1;
    endtask

    task automatic model_advance();
        case (m_phase)
            0: begin
                int g;
                g = pick(in_req);
                if (g >= 0) begin
                    m_owner = g;
                    m_addr  = in_addr[g*AW +: AW];
                    m_din   = in_din[g*DW +: DW];
                    m_we    = in_we[g];
                    m_phase = 1;
                    if (g != 0) m_next = 3 - g;
                    ctl_cnt = rnd_dly ? int'($urandom_range(3)) : ack_dly;
                end
            end
            1: if (sdram_ack) begin
                m_phase = m_we ? 0 : 2;
                ctl_cnt = rnd_dly ? int'($urandom_range(4)) : val_dly;
            end
            2: if (sdram_valid) m_phase = 0;
            default: m_phase = 0;
        endcase
    endtask

    // Drive requesters and the controller for the coming cycle (called just after negedge)
    task automatic env_drive();
        for (int p = 0; p < 3; p++) begin
            if (last_ack[p]) begin
                pend[p] = 1'b0;
                if (!pw[p]) waitv[p] = 1'b1;
            end
            if (last_valid[p]) waitv[p] = 1'b0;
            if (!pend[p] && !waitv[p] && !last_ack[p] && !last_valid[p] && prob[p] > 0
                && int'($urandom_range(99)) < prob[p]) begin
                pend[p] = 1'b1;
                pa[p]   = AW'($urandom);
                pd[p]   = $urandom;
                pw[p]   = 1'($urandom_range(1));
            end
            in_req[p]            = pend[p];
            in_we[p]             = pw[p];
            in_addr[p*AW +: AW]  = pa[p];
            in_din[p*DW +: DW]   = pd[p];
        end
        sdram_ack   = 1'b0;
        sdram_valid = 1'b0;
        sdram_dout  = $urandom;
        case (m_phase)
            1: begin
                if (ctl_cnt == 0) sdram_ack = 1'b1; else ctl_cnt--;
                if (spur && $urandom_range(7) == 0) sdram_valid = 1'b1;
            end
            2: begin
                if (ctl_cnt == 0) sdram_valid = 1'b1; else ctl_cnt--;
            end
            default: if (spur) begin
                sdram_ack   = ($urandom_range(7) == 0);
                sdram_valid = ($urandom_range(7) == 0);
            end
        endcase
    endtask

    // Compare every output against the model, then advance the model across the next edge
    task automatic cycle();
        logic [2:0] exp_ack, exp_valid;
        #1;
        if (rst) model_reset();
        exp_ack   = 3'b000;
        exp_valid = 3'b000;
        if (m_phase == 1 && sdram_ack)   exp_ack[m_owner]   = 1'b1;
        if (m_phase == 2 && sdram_valid) exp_valid[m_owner] = 1'b1;
        chk("busy", busy, (m_phase != 0));
        chk("sdram_req", sdram_req, (m_phase == 1));
        chk("in_ack", in_ack, exp_ack);
        chk("in_valid", in_valid, exp_valid);
        chk("in_dout", in_dout, sdram_dout);
        if (m_phase == 1) begin
            chk("sdram_addr", sdram_addr, m_addr);
            chk("sdram_we", sdram_we, m_we);
            chk("sdram_din", sdram_din, m_din);
        end
        for (int p = 0; p < 3; p++) if (in_ack[p]) ack_log.push_back(p);
        if (in_valid[0] && t_valid0 < 0) t_valid0 = cyc;
        if (sdram_req && sdram_addr == pa[1] && t_valid0 >= 0 && t_req1 < 0) t_req1 = cyc;
        last_ack   = exp_ack;
        last_valid = exp_valid;
        if (!rst) model_advance();
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        prob[0] = 0; prob[1] = 0; prob[2] = 0;
        spur = 1'b0;
        while ((pend != 3'b000 || waitv != 3'b000 || m_phase != 0) && n < 100) begin
            env_drive();
            cycle();
            n++;
        end
        chk("drain_timeout", (n >= 100), 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        in_req = '0; in_we = '0; in_addr = '0; in_din = '0;
        sdram_ack = 1'b0; sdram_valid = 1'b0; sdram_dout = '0;
        pend = '0; waitv = '0; last_ack = '0; last_valid = '0;
        for (int p = 0; p < 3; p++) begin pa[p] = '0; pd[p] = '0; pw[p] = 1'b0; prob[p] = 0; end
        ack_dly = 0; val_dly = 0; ctl_cnt = 0; rnd_dly = 1'b0; spur = 1'b0;
        t_valid0 = -1; t_req1 = -1;
        model_reset();
        @(negedge clk);
        cycle();
        chk("reset_busy", busy, 1'b0);
        chk("reset_sdram_req", sdram_req, 1'b0);
        chk("reset_in_ack", in_ack, 3'b000);
        rst = 1'b0;

        // Port 0 write: command visible one cycle after the request
        pend[0] = 1'b1; pw[0] = 1'b1; pa[0] = 23'h000010; pd[0] = 32'hDEADBEEF;
        env_drive(); cycle();
        chk("wr_req", sdram_req, 1'b1);
        chk("wr_addr", sdram_addr, 23'h000010);
        chk("wr_din", sdram_din, 32'hDEADBEEF);
        chk("wr_we", sdram_we, 1'b1);
        env_drive(); #1;
        chk("wr_ack", in_ack, 3'b001);
        cycle();
        env_drive(); #1;
        chk("wr_idle_busy", busy, 1'b0);
        chk("wr_idle_req", sdram_req, 1'b0);
        cycle();

        // Stray read strobe while idle is ignored
        env_drive(); sdram_valid = 1'b1;
        cycle();
        chk("idle_valid", in_valid, 3'b000);
        chk("idle_busy", busy, 1'b0);

        // Ports 1 and 2 held: grants alternate 1,2,1,2
        prob[1] = 100; prob[2] = 100; ack_dly = 2; val_dly = 3;
        ack_log.delete();
        for (int i = 0; i < 200 && ack_log.size() < 4; i++) begin env_drive(); cycle(); end
        chk("rr_count", (ack_log.size() >= 4), 1'b1);
        if (ack_log.size() >= 4) begin
            chk("rr_grant0", ack_log[0], 1);
            chk("rr_grant1", ack_log[1], 2);
            chk("rr_grant2", ack_log[2], 1);
            chk("rr_grant3", ack_log[3], 2);
        end
        drain();

        // Ports 0 and 1 together: 0 first, 1 sampled right after 0 completes
        ack_dly = 1; val_dly = 1;
        pend[0] = 1'b1; pw[0] = 1'b0; pa[0] = 23'h001234; pd[0] = 32'h0;
        pend[1] = 1'b1; pw[1] = 1'b0; pa[1] = 23'h005678; pd[1] = 32'h0;
        ack_log.delete(); t_valid0 = -1; t_req1 = -1;
        for (int i = 0; i < 60 && ack_log.size() < 2; i++) begin env_drive(); cycle(); end
        chk("prio_count", (ack_log.size() >= 2), 1'b1);
        if (ack_log.size() >= 2) begin
            chk("prio_first", ack_log[0], 0);
            chk("prio_second", ack_log[1], 1);
        end
        chk("prio_gap", t_req1 - t_valid0, 2);
        drain();

        // Randomized traffic with stray controller strobes
        prob[0] = 5; prob[1] = 30; prob[2] = 30; rnd_dly = 1'b1; spur = 1'b1;
        for (int i = 0; i < 3000; i++) begin env_drive(); cycle(); end
        rnd_dly = 1'b0;
        drain();

        // Reset while waiting for read data
        ack_dly = 0; val_dly = 20;
        pend[1] = 1'b1; pw[1] = 1'b0; pa[1] = 23'h000ABC;
        for (int i = 0; i < 20 && m_phase != 2; i++) begin env_drive(); cycle(); end
        chk("rst_reached_wait", busy, 1'b1);
        rst = 1'b1;
        sdram_ack = 1'b0; sdram_valid = 1'b0;
        pend = '0; waitv = '0; last_ack = '0; last_valid = '0;
        in_req = '0;
        cycle();
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", sdram_req, 1'b0);
        chk("rst_ack", in_ack, 3'b000);
        chk("rst_valid", in_valid, 3'b000);
        rst = 1'b0;
        env_drive(); sdram_valid = 1'b1; #1;
        chk("rst_late_valid", in_valid, 3'b000);
        cycle();
        pend[2] = 1'b1; pw[2] = 1'b1; pa[2] = 23'h002222; pd[2] = 32'h12345678;
        env_drive(); cycle();
        chk("rst_p2_req", sdram_req, 1'b1);
        chk("rst_p2_addr", sdram_addr, 23'h002222);
        env_drive(); #1;
        chk("rst_p2_ack", in_ack, 3'b100);
        cycle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
